// File: rtl/softmax_stream_pkg.sv
// Shared configuration, FSM state type and the exp(-k/16) lookup table for softmax_stream.
// The LUT is built at elaboration time with 60-bit fixed-point arithmetic.
package softmax_stream_pkg;

   localparam int unsigned MAX_LEN   = 64;
   localparam int unsigned IN_W      = 16;
   localparam int unsigned FRAC_W    = 8;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned LUT_IDX_W = 8;
   localparam int unsigned LUT_SIZE  = 2 ** LUT_IDX_W;
   localparam int unsigned SUM_W     = OUT_W + $clog2(MAX_LEN);
   localparam int unsigned RECIP_W   = OUT_W + 1;
   localparam int unsigned CNT_W     = $clog2(MAX_LEN) + 1;
   localparam int unsigned ADDR_W    = $clog2(MAX_LEN);
   localparam int unsigned DIV_ITERS = 2 * OUT_W + 1;

   typedef enum logic [1:0] {StIdle, StExp, StDiv, StOut} state_e;

   // LUT[k] = round(65535 * e^(-k/16)), last entry forced to 0
   function automatic logic [LUT_SIZE*OUT_W-1:0] gen_exp_lut();
      logic [127:0]              one;
      logic [127:0]              step;
      logic [127:0]              term;
      logic [127:0]              val;
      logic [127:0]              ent;
      logic [LUT_SIZE*OUT_W-1:0] lut;
      one  = 128'd1 << 60;
      step = one;
      term = one;
      for (int n = 1; n < 16; n++) begin
         term = term / 128'(16 * n);
         step = (n % 2 == 1) ? step - term : step + term;
      end
      val = one;
      lut = '0;
      for (int unsigned k = 0; k < LUT_SIZE; k++) begin
         ent = (val * 128'd65535 + (128'd1 << 59)) >> 60;
         lut[k*OUT_W +: OUT_W] = (k == LUT_SIZE - 1) ? '0 : ent[OUT_W-1:0];
         val = (val * step) >> 60;
      end
      return lut;
   endfunction

   localparam logic [LUT_SIZE*OUT_W-1:0] EXP_LUT = gen_exp_lut();

   function automatic logic [OUT_W-1:0] exp_lut(input logic [LUT_IDX_W-1:0] idx);
      return EXP_LUT[32'(idx) * OUT_W +: OUT_W];
   endfunction

endpackage

// File: rtl/softmax_recip_div.sv
// Sequential restoring divider producing floor(2^(2*OUT_W) / sum), one quotient bit per cycle.
// A zero sum yields a zero reciprocal.
module softmax_recip_div
   import softmax_stream_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [SUM_W-1:0]   sum_i,
   output logic               done_o,
   output logic [RECIP_W-1:0] recip_o
);

   localparam int unsigned IterW = $clog2(DIV_ITERS);

   logic               busy_q;
   logic [IterW-1:0]   iter_q;
   logic [SUM_W-1:0]   den_q;
   logic [SUM_W-1:0]   rem_q;
   logic [SUM_W-1:0]   rem_d;
   logic [SUM_W:0]     rem_shift;
   logic [RECIP_W-1:0] quo_q;
   logic [RECIP_W-1:0] quo_d;
   logic               zero_q;
   logic               q_bit;

   always_comb begin
      // the dividend is a single 1 in its MSB, which is consumed on the first iteration
      rem_shift = {rem_q, iter_q == '0};
      q_bit     = rem_shift >= {1'b0, den_q};
      rem_d     = q_bit ? SUM_W'(rem_shift - {1'b0, den_q}) : rem_shift[SUM_W-1:0];
      quo_d     = {quo_q[RECIP_W-2:0], q_bit};
   end

   assign done_o  = busy_q && (iter_q == IterW'(DIV_ITERS - 1));
   assign recip_o = zero_q ? '0 : quo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         iter_q <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         zero_q <= 1'b0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         iter_q <= '0;
         den_q  <= sum_i;
         rem_q  <= '0;
         quo_q  <= '0;
         zero_q <= (sum_i == '0);
      end else if (busy_q) begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         iter_q <= iter_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/softmax_stream.sv
// Element-serial softmax: load logits, exp via LUT, reciprocal of the sum, stream Q0.16 results.
// Define SOFTMAX_STREAM_MASK_EN to add the in_mask input and the all_masked status output.
module softmax_stream
   import softmax_stream_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
`ifdef SOFTMAX_STREAM_MASK_EN
   input  logic             in_mask,
   output logic             all_masked,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             len_trunc
);

   localparam logic signed [IN_W-1:0] MaxNeg = {1'b1, {(IN_W - 1){1'b0}}};

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]        idx_q, idx_d;
   logic signed [IN_W-1:0]  max_q, max_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic                    trunc_q, trunc_d;
   logic [IN_W-1:0]         mem_q [MAX_LEN];
   logic [IN_W-1:0]         rd_q;
   logic signed [IN_W:0]    diff;
   logic [IN_W:0]           mag;
   logic [IN_W:0]           shifted;
   logic [LUT_IDX_W-1:0]    lut_idx;
   logic [OUT_W-1:0]        exp_val;
   logic [OUT_W+RECIP_W-1:0] prod;
   logic [RECIP_W-1:0]      scaled;
   logic [RECIP_W-1:0]      recip;
   logic                    div_start, div_done;
   logic                    in_mask_w, elem_mask;

`ifdef SOFTMAX_STREAM_MASK_EN
   logic mask_mem_q [MAX_LEN];
   logic mask_rd_q, all_masked_q;

   assign in_mask_w  = in_mask;
   assign elem_mask  = mask_rd_q;
   assign all_masked = all_masked_q;

   always_ff @(posedge clk) begin
      if (state_q == StIdle && in_valid) mask_mem_q[count_q[ADDR_W-1:0]] <= in_mask;
      if (state_q == StExp) mask_rd_q <= mask_mem_q[idx_q[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) all_masked_q <= 1'b0;
      else if (div_start) all_masked_q <= (sum_d == '0);
      else if (state_q == StIdle && in_valid && count_q == '0) all_masked_q <= 1'b0;
   end
`else
   assign in_mask_w = 1'b0;
   assign elem_mask = 1'b0;
`endif

   always_comb begin
      diff    = $signed({rd_q[IN_W-1], rd_q}) - $signed({max_q[IN_W-1], max_q});
      mag     = -diff;
      shifted = mag >> (FRAC_W - 4);
      lut_idx = (shifted > (IN_W + 1)'(LUT_SIZE - 1)) ? '1 : shifted[LUT_IDX_W-1:0];
      exp_val = elem_mask ? '0 : exp_lut(lut_idx);
      prod    = {{RECIP_W{1'b0}}, mem_q[idx_q[ADDR_W-1:0]]} * {{OUT_W{1'b0}}, recip};
      scaled  = RECIP_W'(prod >> OUT_W);
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      idx_d     = idx_q;
      max_d     = max_q;
      sum_d     = sum_q;
      trunc_d   = 1'b0;
      div_start = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            sum_d    = '0;
            idx_d    = '0;
            if (in_valid) begin
               count_d = count_q + 1'b1;
               if (!in_mask_w && $signed(in_data) > max_q) max_d = in_data;
               if (in_last || count_q == CNT_W'(MAX_LEN - 1)) begin
                  state_d = StExp;
                  trunc_d = !in_last;
               end
            end
         end
         StExp: begin
            // buffer read is registered: element idx-1 is converted while idx is fetched
            idx_d = idx_q + 1'b1;
            if (idx_q != '0) sum_d = sum_q + SUM_W'(exp_val);
            if (idx_q == count_q) begin
               state_d   = StDiv;
               div_start = 1'b1;
               idx_d     = '0;
            end
         end
         StDiv: begin
            if (div_done) state_d = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            out_last  = (idx_q == count_q - 1'b1);
            if (out_ready) begin
               idx_d = idx_q + 1'b1;
               if (out_last) begin
                  state_d = StIdle;
                  count_d = '0;
                  idx_d   = '0;
                  max_d   = MaxNeg;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign out_data  = (state_q == StOut) ?
                      (scaled[RECIP_W-1] ? '1 : scaled[OUT_W-1:0]) : '0;
   assign busy      = (state_q != StIdle);
   assign len_trunc = trunc_q;

   always_ff @(posedge clk) begin
      if (state_q == StIdle && in_valid) mem_q[count_q[ADDR_W-1:0]] <= in_data;
      if (state_q == StExp && idx_q != '0) mem_q[ADDR_W'(idx_q - 1'b1)] <= exp_val;
      if (state_q == StExp) rd_q <= mem_q[idx_q[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         idx_q   <= '0;
         max_q   <= MaxNeg;
         sum_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         trunc_q <= trunc_d;
      end
   end

   softmax_recip_div u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (div_start),
      .sum_i   (sum_d),
      .done_o  (div_done),
      .recip_o (recip)
   );

endmodule
